// File: rtl/svm_classifier_sdiv_26s_15s_13_seq.sv
// Sequential radix-2 restoring signed divider with saturated quotient.
// Dividend and divisor are converted to magnitudes. Signs and saturation are applied in one fix-up cycle.
module svm_classifier_sdiv_26s_15s_13_seq #(
  parameter int DIVIDEND_WIDTH = 26,
  parameter int DIVISOR_WIDTH  = 15,
  parameter int QUOTIENT_WIDTH = 13
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      ovf,
  output logic                      dz
);

  localparam int N  = DIVIDEND_WIDTH;
  localparam int M  = DIVISOR_WIDTH;
  localparam int Q  = QUOTIENT_WIDTH;
  localparam int CW = $clog2(N);

  localparam logic [Q-1:0] QMAX    = {1'b0, {(Q-1){1'b1}}};
  localparam logic [Q-1:0] QMIN    = {1'b1, {(Q-1){1'b0}}};
  localparam logic [N-1:0] POS_LIM = N'(QMAX);
  localparam logic [N-1:0] NEG_LIM = N'(QMIN);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [M-1:0]  dvs_q, dvs_d;
  logic [M:0]    rem_q, rem_d;
  logic          sd_q, sd_d, sv_q, sv_d, dzi_q, dzi_d, rdy_q, rdy_d;
  logic [Q-1:0]  quot_q, quot_d;
  logic [M-1:0]  remo_q, remo_d;
  logic          ovf_q, ovf_d, dzo_q, dzo_d;

  logic [M+1:0]  rem_sh, dvs_ext;
  logic          ge, neg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    sd_d    = sd_q;
    sv_d    = sv_q;
    dzi_d   = dzi_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ovf_d   = ovf_q;
    dzo_d   = dzo_q;

    rem_sh  = {rem_q, dvd_q[N-1]};
    dvs_ext = {2'b00, dvs_q};
    ge      = (rem_sh >= dvs_ext);
    neg     = sd_q ^ sv_q;

    case (state_q)
      S_IDLE: begin
        if (din_valid && rdy_q) begin
          dvd_d   = dividend[N-1] ? ('0 - dividend) : dividend;
          dvs_d   = divisor[M-1]  ? ('0 - divisor)  : divisor;
          sd_d    = dividend[N-1];
          sv_d    = divisor[M-1];
          dzi_d   = (divisor == '0);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        // dvd_q doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom.
        rem_d = ge ? (M+1)'(rem_sh - dvs_ext) : rem_sh[M:0];
        dvd_d = {dvd_q[N-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_OUT;
        if (dzi_q) begin
          quot_d = sd_q ? QMIN : QMAX;
          remo_d = '0;
          ovf_d  = 1'b1;
          dzo_d  = 1'b1;
        end else begin
          remo_d = sd_q ? ('0 - rem_q[M-1:0]) : rem_q[M-1:0];
          dzo_d  = 1'b0;
          if (!neg && dvd_q > POS_LIM) begin
            quot_d = QMAX;
            ovf_d  = 1'b1;
          end else if (neg && dvd_q > NEG_LIM) begin
            quot_d = QMIN;
            ovf_d  = 1'b1;
          end else begin
            quot_d = neg ? ('0 - dvd_q[Q-1:0]) : dvd_q[Q-1:0];
            ovf_d  = 1'b0;
          end
        end
      end
      S_OUT: begin
        if (dout_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      dzi_q   <= 1'b0;
      rdy_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      ovf_q   <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      dzi_q   <= dzi_d;
      rdy_q   <= rdy_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ovf_q   <= ovf_d;
      dzo_q   <= dzo_d;
    end
  end

  assign din_ready  = rdy_q;
  assign dout_valid = (state_q == S_OUT);
  assign quotient   = quot_q;
  assign remainder  = remo_q;
  assign ovf        = ovf_q;
  assign dz         = dzo_q;

endmodule

// File: tb/tb_svm_classifier_sdiv_26s_15s_13_seq.sv
// Scoreboard bench for the sequential signed divider.
// The reference model uses plain integer division with truncation and clamping.
module tb_svm_classifier_sdiv_26s_15s_13_seq;

  localparam int N = 26;
  localparam int M = 15;
  localparam int Q = 13;
  localparam longint LAT = N + 1;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [N-1:0] dividend = '0;
  logic [M-1:0] divisor = '0;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic [Q-1:0] quotient;
  logic [M-1:0] remainder;
  logic         ovf;
  logic         dz;

  svm_classifier_sdiv_26s_15s_13_seq #(
    .DIVIDEND_WIDTH(N),
    .DIVISOR_WIDTH (M),
    .QUOTIENT_WIDTH(Q)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint q;
    longint r;
    longint ovf;
    longint dz;
    longint acc;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  logic   rand_rdy = 1'b0;
  logic   rdy_force = 1'b1;
  logic   vprev = 1'b0;

  always @(posedge ap_clk) cyc++;

  always @(posedge ap_clk) begin
    #2 dout_ready = rand_rdy ? ($urandom_range(3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [M-1:0] b);
    exp_t   e;
    longint sa, sb, tq;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.acc = 0;
    if (sb == 0) begin
      e.q   = (sa >= 0) ? 4095 : -4096;
      e.r   = 0;
      e.ovf = 1;
      e.dz  = 1;
    end else begin
      tq    = sa / sb;
      e.r   = sa % sb;
      e.dz  = 0;
      e.ovf = (tq > 4095 || tq < -4096) ? 1 : 0;
      e.q   = (tq > 4095) ? 4095 : (tq < -4096) ? -4096 : tq;
    end
    return e;
  endfunction

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      vprev = 1'b0;
    end else begin
      if (dout_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_dout_valid", 1, 0);
        end else begin
          mon_e = sbq[0];
          if (!vprev) chk("latency", cyc - mon_e.acc, LAT);
          chk("quotient",  longint'($signed(quotient)),  mon_e.q);
          chk("remainder", longint'($signed(remainder)), mon_e.r);
          chk("ovf", longint'(ovf), mon_e.ovf);
          chk("dz",  longint'(dz),  mon_e.dz);
          if (dout_ready) void'(sbq.pop_front());
        end
      end
      vprev = dout_valid;
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [M-1:0] b);
    exp_t e;
    int   n;
    @(negedge ap_clk);
    din_valid = 1'b1;
    dividend  = a;
    divisor   = b;
    n = 0;
    while (!din_ready && n < 300) begin
      @(negedge ap_clk);
      n++;
    end
    chk("accept_wait", longint'(din_ready), 1);
    if (!din_ready) begin
      din_valid = 1'b0;
      return;
    end
    e     = model(a, b);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(posedge ap_clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge ap_clk);
      n++;
    end
    chk("drain", longint'(sbq.size()), 0);
  endtask

  int da[14] = '{1000, -1000, 1000, -1000, 100000, -100000, -4096, -33554432,
                 5, -5, 0, 33554431, 12285, -33554432};
  int db[14] = '{7, 7, -7, -7, 3, 3, 1, -1, 0, 0, 0, -16384, 3, -16384};

  initial begin
    #12;
    chk("rst_din_ready",  longint'(din_ready), 0);
    chk("rst_dout_valid", longint'(dout_valid), 0);
    chk("rst_quotient",   longint'(quotient), 0);
    chk("rst_remainder",  longint'(remainder), 0);
    chk("rst_ovf",        longint'(ovf), 0);
    chk("rst_dz",         longint'(dz), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("idle_din_ready", longint'(din_ready), 1);

    for (int i = 0; i < 14; i++) begin
      send(N'(da[i]), M'(db[i]));
      drain();
    end

    // Back-pressure: result must stay put and new operands must be ignored.
    rdy_force = 1'b0;
    send(N'(1000), M'(7));
    for (int n = 0; n < 100 && !dout_valid; n++) @(negedge ap_clk);
    chk("hold_valid_seen", longint'(dout_valid), 1);
    din_valid = 1'b1;
    dividend  = N'(5);
    divisor   = M'(1);
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      chk("hold_dout_valid", longint'(dout_valid), 1);
      chk("hold_din_ready",  longint'(din_ready), 0);
    end
    din_valid = 1'b0;
    rdy_force = 1'b1;
    drain();
    @(negedge ap_clk);
    chk("post_hs_din_ready",  longint'(din_ready), 1);
    chk("post_hs_dout_valid", longint'(dout_valid), 0);

    // Asynchronous reset in the middle of the iteration phase.
    send(N'(1000), M'(7));
    repeat (11) @(posedge ap_clk);
    #3 ap_rst_n = 1'b0;
    #1;
    chk("midrst_dout_valid", longint'(dout_valid), 0);
    chk("midrst_quotient",   longint'(quotient), 0);
    chk("midrst_remainder",  longint'(remainder), 0);
    chk("midrst_ovf",        longint'(ovf), 0);
    chk("midrst_din_ready",  longint'(din_ready), 0);
    sbq.delete();
    repeat (3) @(negedge ap_clk);
    chk("midrst_no_valid", longint'(dout_valid), 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    send(N'(1000), M'(7));
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] ra;
      logic [M-1:0] rb;
      ra = N'($urandom);
      rb = M'($urandom);
      case ($urandom_range(3))
        0: ra = N'(int'($urandom_range(20000)) - 10000);
        1: ra = (i % 2 == 0) ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        default: ;
      endcase
      case ($urandom_range(7))
        0: rb = '0;
        1, 2: rb = M'(int'($urandom_range(40)) - 20);
        3: rb = M'(-1);
        default: ;
      endcase
      send(ra, rb);
    end
    drain();
    rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
